// File: rtl/pipe_pkg.sv
// Shared geometry constants and segment-state encoding for the pipe outline walkers.
package pipe_pkg;

    localparam int PIPE_W   = 60;
    localparam int BEVEL    = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int LIP_W    = PIPE_W + 2 * BEVEL;
    localparam int CW       = 11;
    localparam int GW       = CW + 1;

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S2,
        S3,
        S4,
        S5,
        S6,
        S7
    } seg_t;

endpackage

// File: rtl/pipe_seg_clip.sv
// Resolves one outline segment into a clipped start point, step direction and length.
module pipe_seg_clip
    import pipe_pkg::*;
(
    input  seg_t          seg,
    input  logic [CW-1:0] px,
    input  logic [CW-1:0] py,
    output logic          vert,
    output logic          up,
    output logic          empty,
    output logic [CW-1:0] fixed,
    output logic [CW-1:0] start,
    output logic [CW-1:0] len_m1
);

    localparam logic signed [GW-1:0] XMAX = GW'(SCREEN_W - 1);

    logic signed [GW-1:0] gx, gy, ll, bl, br, lr, lb, yend;
    logic signed [GW-1:0] fx, s, e, cs, ce, len;

    assign gx   = signed'({1'b0, px});
    assign gy   = signed'({1'b0, py});
    assign ll   = gx - GW'(LIP_W);
    assign bl   = gx - GW'(LIP_W - BEVEL);
    assign br   = gx - GW'(BEVEL);
    assign lr   = gx;
    assign lb   = gy + GW'(BEVEL);
    assign yend = GW'(SCREEN_H - 1);

    always_comb begin
        vert = 1'b0;
        up   = 1'b0;
        fx   = '0;
        s    = '0;
        e    = '0;
        case (seg)
            S1:      begin vert = 1'b1;              fx = bl; s = yend; e = lb;   end
            S2:      begin                           fx = lb; s = bl;   e = ll;   end
            S3:      begin vert = 1'b1;              fx = ll; s = lb;   e = gy;   end
            S4:      begin              up = 1'b1;   fx = gy; s = ll;   e = lr;   end
            S5:      begin vert = 1'b1; up = 1'b1;   fx = lr; s = gy;   e = lb;   end
            S6:      begin                           fx = lb; s = lr;   e = br;   end
            S7:      begin vert = 1'b1; up = 1'b1;   fx = br; s = lb;   e = yend; end
            default: ;
        endcase

        // Vertical runs are always on-screen in y, so only their x decides; horizontal runs get x clipped.
        cs    = s;
        ce    = e;
        empty = 1'b0;
        if (seg == IDLE) begin
            empty = 1'b1;
        end else if (vert) begin
            empty = fx[GW-1] || (fx > XMAX);
        end else if (up) begin
            if (s[GW-1]) cs = '0;
            if (e > XMAX) ce = XMAX;
            empty = cs > ce;
        end else begin
            if (s > XMAX) cs = XMAX;
            if (e[GW-1]) ce = '0;
            empty = cs < ce;
        end

        len    = up ? (ce - cs) : (cs - ce);
        fixed  = fx[CW-1:0];
        start  = cs[CW-1:0];
        len_m1 = len[CW-1:0];
    end

endmodule

// File: rtl/pipe_drawer.sv
// Lower pipe outline walker: emits one clipped on-screen pixel per clock along seven segments.
module pipe_drawer
    import pipe_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [CW-1:0] pipe_x,
    input  logic [CW-1:0] pipe_y,
    output logic          done,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y
);

    seg_t          state, nxt;
    logic [CW-1:0] px_r, py_r, gx, gy, py_clamp, cnt;
    logic [7:1]    vert, up, empty;
    logic [CW-1:0] fixed  [1:7];
    logic [CW-1:0] start  [1:7];
    logic [CW-1:0] len_m1 [1:7];
    logic          has_next, last_next;

    assign py_clamp = (pipe_y > CW'(SCREEN_H - 1 - BEVEL)) ? CW'(SCREEN_H - 1 - BEVEL) : pipe_y;
    // In IDLE the live inputs feed the clippers so the first pixel is ready on the starting edge.
    assign gx = (state == IDLE) ? pipe_x : px_r;
    assign gy = (state == IDLE) ? py_clamp : py_r;

    for (genvar g = 1; g <= 7; g++) begin : g_seg
        pipe_seg_clip u_clip (
            .seg    (seg_t'(3'(g))),
            .px     (gx),
            .py     (gy),
            .vert   (vert[g]),
            .up     (up[g]),
            .empty  (empty[g]),
            .fixed  (fixed[g]),
            .start  (start[g]),
            .len_m1 (len_m1[g])
        );
    end

    always_comb begin
        nxt       = IDLE;
        has_next  = 1'b0;
        last_next = 1'b1;
        for (int unsigned k = 1; k <= 7; k++) begin
            if (!empty[k] && (k > 32'(state))) begin
                if (!has_next) begin
                    nxt      = seg_t'(k[2:0]);
                    has_next = 1'b1;
                end else begin
                    last_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            done  <= 1'b0;
            cnt   <= '0;
            px_r  <= '0;
            py_r  <= '0;
        end else if (state != IDLE && cnt != '0) begin
            if (vert[state]) y <= up[state] ? y + 1'b1 : y - 1'b1;
            else             x <= up[state] ? x + 1'b1 : x - 1'b1;
            cnt  <= cnt - 1'b1;
            done <= (cnt == CW'(1)) && !has_next;
        end else if (has_next && (state != IDLE || enable)) begin
            if (state == IDLE) begin
                px_r <= pipe_x;
                py_r <= py_clamp;
            end
            state <= nxt;
            x     <= vert[nxt] ? fixed[nxt] : start[nxt];
            y     <= vert[nxt] ? start[nxt] : fixed[nxt];
            cnt   <= len_m1[nxt];
            done  <= (len_m1[nxt] == '0) && last_next;
        end else begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_drawer.sv
// Randomized self-checking bench for pipe_drawer against a point-list outline model.
module tb_pipe_drawer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [10:0] pipe_x, pipe_y;
    logic        done;
    logic [10:0] x, y;

    int n_checks = 0;
    int n_errors = 0;
    int exp_x[$];
    int exp_y[$];

    pipe_drawer dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .pipe_x (pipe_x),
        .pipe_y (pipe_y),
        .done   (done),
        .x      (x),
        .y      (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void put(input int px, input int py);
        if (px >= 0 && px < 640 && py >= 0 && py < 480) begin
            exp_x.push_back(px);
            exp_y.push_back(py);
        end
    endfunction

    // Every point of the seven inclusive segments in order, dropping off-screen points.
    function automatic void build(input int px, input int py_in);
        int py, ll, bl, br, lr, lb;
        exp_x.delete();
        exp_y.delete();
        py = (py_in > 469) ? 469 : py_in;
        ll = px - 80; bl = px - 70; br = px - 10; lr = px; lb = py + 10;
        for (int v = 479; v >= lb; v--) put(bl, v);
        for (int v = bl; v >= ll; v--)  put(v, lb);
        for (int v = lb; v >= py; v--)  put(ll, v);
        for (int v = ll; v <= lr; v++)  put(v, py);
        for (int v = py; v <= lb; v++)  put(lr, v);
        for (int v = lr; v >= br; v--)  put(v, lb);
        for (int v = lb; v <= 479; v++) put(br, v);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_x"}, int'(x), 0);
        check({tag, "_y"}, int'(y), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // Entered and left at #1 after a rising edge with the DUT in IDLE.
    task automatic draw(input int px, input int py, input bit keep);
        int n;
        build(px, py);
        n = exp_x.size();
        pipe_x = 11'(px);
        pipe_y = 11'(py);
        enable = 1'b1;
        @(posedge clk); #1;
        if (!keep) begin
            enable = 1'b0;
            pipe_x = 11'($urandom_range(0, 2047));
            pipe_y = 11'($urandom_range(0, 2047));
        end
        for (int i = 0; i < n; i++) begin
            check("pix_x", int'(x), exp_x[i]);
            check("pix_y", int'(y), exp_y[i]);
            check("pix_done", int'(done), (i == n - 1) ? 1 : 0);
            @(posedge clk); #1;
        end
        check_idle("after_draw");
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        pipe_x = '0;
        pipe_y = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle("idle");
        end

        draw(200, 300, 1'b0);
        draw(50, 380, 1'b0);
        draw(9, 380, 1'b0);
        draw(700, 100, 1'b0);
        draw(0, 2047, 1'b0);
        draw(719, 0, 1'b0);

        // enable held through the done cycle starts the next draw after one idle cycle
        draw(120, 250, 1'b1);
        draw(120, 250, 1'b0);

        for (int r = 0; r < 30; r++)
            draw(int'($urandom_range(0, 719)), int'($urandom_range(0, 2047)), 1'b0);

        // mid-draw input change is ignored, then reset aborts
        build(200, 300);
        pipe_x = 11'd200;
        pipe_y = 11'd300;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) pipe_x = 11'd400;
            check("abort_x", int'(x), exp_x[i]);
            check("abort_y", int'(y), exp_y[i]);
            check("abort_done", int'(done), 0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("abort_reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle("abort_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
